// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and widths for the pipeline stall/flush/freeze controller.
// REG_ADDR_W mirrors the register-file address width of the ARM core.
package pipeline_ctrl_pkg;

    localparam int REG_ADDR_W = 4;

    typedef enum logic {
        PCTRL_RUN      = 1'b0,
        PCTRL_MEM_WAIT = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Read-after-write hazard compare between the ID-stage sources and the EXE/MEM producers.
module hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src1_valid,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  forward_en,
    output logic                  hazard
);

    logic matchExe;
    logic matchMem;

    assign matchExe = (src1_valid && (src1 == exe_dest)) || (two_src && (src2 == exe_dest));
    assign matchMem = (src1_valid && (src1 == mem_dest)) || (two_src && (src2 == mem_dest));

    // With forwarding only a load in EXE cannot be bypassed in time.
    assign hazard = forward_en ? (exe_mem_read && exe_wb_en && matchExe)
                               : ((exe_wb_en && matchExe) || (mem_wb_en && matchMem));

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/freeze controller: prioritises memory freeze over branch flush
// over hazard stall, and keeps saturating debug counters plus a sticky memory timeout.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int COUNT_W = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] src1,
    input  logic [REG_ADDR_W-1:0] src2,
    input  logic                  src1_valid,
    input  logic                  two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  forward_en,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  hold_pc,
    output logic                  hold_if_id,
    output logic                  flush_if_id,
    output logic                  flush_id_exe,
    output logic                  freeze,
    output logic                  mem_timeout,
    output logic [COUNT_W-1:0]    stall_count,
    output logic [COUNT_W-1:0]    flush_count,
    output logic [COUNT_W-1:0]    freeze_count
);

    localparam logic [COUNT_W-1:0] CNT_ONE      = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] TIMEOUT_CNT  = COUNT_W'(TIMEOUT);
    localparam logic [COUNT_W-1:0] TIMEOUT_LAST = COUNT_W'(TIMEOUT - 1);

    ctrl_state_e        state_q, state_d;
    logic [COUNT_W-1:0] waitCnt_q, waitCnt_d;
    logic               timeout_q, timeout_d;
    logic [COUNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [COUNT_W-1:0] flushCnt_q, flushCnt_d;
    logic [COUNT_W-1:0] freezeCnt_q, freezeCnt_d;
    logic               hazard;

    function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    hazard_detect u_hazard (
        .src1         (src1),
        .src2         (src2),
        .src1_valid   (src1_valid),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .forward_en   (forward_en),
        .hazard       (hazard)
    );

    always_comb begin
        state_d      = state_q;
        waitCnt_d    = waitCnt_q;
        timeout_d    = timeout_q;
        stallCnt_d   = stallCnt_q;
        flushCnt_d   = flushCnt_q;
        freezeCnt_d  = freezeCnt_q;
        freeze       = 1'b0;
        hold_pc      = 1'b0;
        hold_if_id   = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;

        // Reset forces every control output low even while inputs keep toggling.
        if (!rst) begin
            case (state_q)
                PCTRL_RUN: begin
                    freeze = mem_req && !mem_ready;
                    if (freeze) begin
                        state_d   = PCTRL_MEM_WAIT;
                        waitCnt_d = '0;
                    end
                end
                PCTRL_MEM_WAIT: begin
                    freeze = !mem_ready;
                    if (mem_ready) begin
                        state_d = PCTRL_RUN;
                    end
                    if (waitCnt_q != TIMEOUT_CNT) begin
                        waitCnt_d = waitCnt_q + CNT_ONE;
                    end
                    if (waitCnt_q == TIMEOUT_LAST) begin
                        timeout_d = 1'b1;
                    end
                end
                default: state_d = PCTRL_RUN;
            endcase

            if (freeze) begin
                freezeCnt_d = satInc(freezeCnt_q);
            end else if (branch_taken) begin
                flush_if_id  = 1'b1;
                flush_id_exe = 1'b1;
                flushCnt_d   = satInc(flushCnt_q);
            end else if (hazard) begin
                hold_pc      = 1'b1;
                hold_if_id   = 1'b1;
                flush_id_exe = 1'b1;
                stallCnt_d   = satInc(stallCnt_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= PCTRL_RUN;
            waitCnt_q   <= '0;
            timeout_q   <= 1'b0;
            stallCnt_q  <= '0;
            flushCnt_q  <= '0;
            freezeCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            waitCnt_q   <= waitCnt_d;
            timeout_q   <= timeout_d;
            stallCnt_q  <= stallCnt_d;
            flushCnt_q  <= flushCnt_d;
            freezeCnt_q <= freezeCnt_d;
        end
    end

    assign mem_timeout  = timeout_q;
    assign stall_count  = stallCnt_q;
    assign flush_count  = flushCnt_q;
    assign freeze_count = freezeCnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized bench for pipeline_ctrl, compared cycle by cycle
// against a behavioural model of the stall/flush/freeze rules.
module tb_pipeline_ctrl;
    import pipeline_ctrl_pkg::*;

    localparam int TB_COUNT_W = 4;
    localparam int TB_TIMEOUT = 8;
    localparam int CNT_MAX    = (1 << TB_COUNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [REG_ADDR_W-1:0] src1, src2, exe_dest, mem_dest;
    logic                  src1_valid, two_src, exe_wb_en, exe_mem_read;
    logic                  mem_wb_en, forward_en, branch_taken, mem_req, mem_ready;
    logic                  hold_pc, hold_if_id, flush_if_id, flush_id_exe, freeze, mem_timeout;
    logic [TB_COUNT_W-1:0] stall_count, flush_count, freeze_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit mWait;
    int mWaitCycles;
    bit mTimeout;
    int mStall, mFlush, mFreeze;
    bit eHoldPc, eHoldIfId, eFlushIfId, eFlushIdExe, eFreeze;

    pipeline_ctrl #(.COUNT_W(TB_COUNT_W), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .src1         (src1),
        .src2         (src2),
        .src1_valid   (src1_valid),
        .two_src      (two_src),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_read (exe_mem_read),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .forward_en   (forward_en),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .hold_pc      (hold_pc),
        .hold_if_id   (hold_if_id),
        .flush_if_id  (flush_if_id),
        .flush_id_exe (flush_id_exe),
        .freeze       (freeze),
        .mem_timeout  (mem_timeout),
        .stall_count  (stall_count),
        .flush_count  (flush_count),
        .freeze_count (freeze_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int s1, input bit s1v, input int s2, input bit ts,
                                 input int ed, input bit ewb, input bit emr,
                                 input int md, input bit mwb, input bit fwd,
                                 input bit br, input bit req, input bit rdy);
        src1 = REG_ADDR_W'(s1);   src1_valid = s1v;
        src2 = REG_ADDR_W'(s2);   two_src = ts;
        exe_dest = REG_ADDR_W'(ed); exe_wb_en = ewb; exe_mem_read = emr;
        mem_dest = REG_ADDR_W'(md); mem_wb_en = mwb; forward_en = fwd;
        branch_taken = br; mem_req = req; mem_ready = rdy;
    endtask

    function automatic bit refHazard();
        bit needsExe = (src1_valid && src1 == exe_dest) || (two_src && src2 == exe_dest);
        bit needsMem = (src1_valid && src1 == mem_dest) || (two_src && src2 == mem_dest);
        if (forward_en) return exe_mem_read && exe_wb_en && needsExe;
        return (exe_wb_en && needsExe) || (mem_wb_en && needsMem);
    endfunction

    task automatic modelReset();
        mWait = 0; mWaitCycles = 0; mTimeout = 0;
        mStall = 0; mFlush = 0; mFreeze = 0;
    endtask

    task automatic computeExpected();
        {eHoldPc, eHoldIfId, eFlushIfId, eFlushIdExe, eFreeze} = '0;
        if (!rst) begin
            eFreeze = mWait ? !mem_ready : (mem_req && !mem_ready);
            if (!eFreeze) begin
                if (branch_taken) begin
                    eFlushIfId = 1; eFlushIdExe = 1;
                end else if (refHazard()) begin
                    eHoldPc = 1; eHoldIfId = 1; eFlushIdExe = 1;
                end
            end
        end
    endtask

    task automatic modelAdvance();
        if (eFreeze && mFreeze < CNT_MAX) mFreeze++;
        if (eFlushIfId && mFlush < CNT_MAX) mFlush++;
        if (eHoldPc && mStall < CNT_MAX) mStall++;
        if (!mWait) begin
            if (eFreeze) begin
                mWait = 1; mWaitCycles = 0;
            end
        end else begin
            mWaitCycles++;
            if (mWaitCycles >= TB_TIMEOUT) mTimeout = 1;
            if (mem_ready) mWait = 0;
        end
    endtask

    task automatic checkComb(input string tag);
        computeExpected();
        checkOutput({tag, ".hold_pc"}, 32'(hold_pc), 32'(eHoldPc));
        checkOutput({tag, ".hold_if_id"}, 32'(hold_if_id), 32'(eHoldIfId));
        checkOutput({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(eFlushIfId));
        checkOutput({tag, ".flush_id_exe"}, 32'(flush_id_exe), 32'(eFlushIdExe));
        checkOutput({tag, ".freeze"}, 32'(freeze), 32'(eFreeze));
    endtask

    task automatic checkRegs(input string tag);
        checkOutput({tag, ".mem_timeout"}, 32'(mem_timeout), 32'(mTimeout));
        checkOutput({tag, ".stall_count"}, 32'(stall_count), 32'(mStall));
        checkOutput({tag, ".flush_count"}, 32'(flush_count), 32'(mFlush));
        checkOutput({tag, ".freeze_count"}, 32'(freeze_count), 32'(mFreeze));
    endtask

    // Called just after a falling edge with inputs already applied.
    task automatic stepCycle(input string tag);
        #1;
        checkComb(tag);
        @(posedge clk);
        if (!rst) modelAdvance();
        #1;
        checkRegs(tag);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        modelReset();
        // Inputs that would otherwise stall/flush/freeze must be masked by reset.
        applyStimulus(3, 1, 0, 0, 3, 1, 1, 0, 0, 0, 1, 1, 0);
        @(negedge clk);
        stepCycle("reset_hold");
        rst = 1'b0;
        idle();
        stepCycle("idle");

        // Load-use with forwarding: a single stall.
        applyStimulus(3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 0, 0, 1);
        stepCycle("loaduse_fwd");
        checkOutput("loaduse_fwd.stall_is_one", 32'(stall_count), 32'd1);
        idle();
        stepCycle("loaduse_after");

        // No forwarding: producer in EXE, then in MEM, then gone.
        applyStimulus(3, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 1);
        stepCycle("nofwd_exe");
        applyStimulus(3, 1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0, 1);
        stepCycle("nofwd_mem");
        checkOutput("nofwd.stall_is_three", 32'(stall_count), 32'd3);
        applyStimulus(3, 1, 0, 0, 3, 1, 0, 3, 1, 1, 0, 0, 1);
        stepCycle("fwd_alu_no_stall");
        applyStimulus(0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1);
        stepCycle("src2_hazard");

        // Branch beats hazard.
        applyStimulus(3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 1, 0, 1);
        stepCycle("branch_over_hazard");
        checkOutput("branch.flush_is_one", 32'(flush_count), 32'd1);

        // Four-cycle freeze with a pending branch, flushed in the fifth cycle.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 1, 1, 0);
            stepCycle($sformatf("freeze_c%0d", i));
        end
        applyStimulus(3, 1, 0, 0, 3, 1, 1, 0, 0, 1, 1, 1, 1);
        stepCycle("freeze_release_branch");
        checkOutput("freeze.count_is_four", 32'(freeze_count), 32'd4);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        stepCycle("req_ready_same_cycle");

        // Timeout after TIMEOUT wait cycles, then asynchronous reset mid-wait.
        for (int i = 0; i < TB_TIMEOUT + 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            stepCycle($sformatf("timeout_c%0d", i));
        end
        checkOutput("timeout.sticky", 32'(mem_timeout), 32'd1);
        #2 rst = 1'b1;
        #1;
        modelReset();
        checkComb("async_reset");
        checkRegs("async_reset");
        @(negedge clk);
        rst = 1'b0;
        idle();
        stepCycle("after_reset");

        // Counter saturation.
        for (int i = 0; i < (1 << TB_COUNT_W) + 3; i++) begin
            applyStimulus(7, 1, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1);
            stepCycle("saturate");
        end
        checkOutput("saturate.stall_max", 32'(stall_count), 32'(CNT_MAX));

        // Random traffic.
        rst = 1'b1;
        #1 modelReset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3), 1'($urandom),
                          $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                          $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                          ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) == 0),
                          ($urandom_range(0, 9) < 6));
            stepCycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush/freeze controller for the five-stage ARM pipeline. It drives the hold and flush inputs of the PC, IF/ID and ID/EX stage registers. It detects read-after-write hazards, converts an EXE-stage taken branch into bubbles, and freezes the whole pipeline while the MEM stage waits on the data-memory handshake. It also keeps saturating event counters and a sticky memory-timeout flag for debug.

## Interface
Parameters:
- COUNT_W, 16, width of each event counter
- TIMEOUT, 64, MEM_WAIT cycles before mem_timeout sets (2..2^COUNT_W-1)

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- src1  in  `REGFILE_ADDRESS_LEN  ID-stage Rn index
- src2  in  `REGFILE_ADDRESS_LEN  ID-stage Rm/Rd-for-store index
- src1_valid  in  1  ID instruction reads src1
- two_src  in  1  ID instruction reads src2
- exe_dest  in  `REGFILE_ADDRESS_LEN  dest reg in EXE
- exe_wb_en  in  1  EXE will write back
- exe_mem_read  in  1  EXE is a load
- mem_dest  in  `REGFILE_ADDRESS_LEN  dest reg in MEM
- mem_wb_en  in  1  MEM will write back
- forward_en  in  1  forwarding unit active
- branch_taken  in  1  EXE branch resolved taken
- mem_req  in  1  MEM stage issues read or write
- mem_ready  in  1  data memory completes request this cycle
- hold_pc  out  1  PC register holds
- hold_if_id  out  1  IF/ID register holds
- flush_if_id  out  1  IF/ID loads bubble
- flush_id_exe  out  1  ID/EX loads bubble (drives stage-register flush)
- freeze  out  1  every stage register holds
- mem_timeout  out  1  sticky: MEM_WAIT exceeded TIMEOUT
- stall_count  out  COUNT_W  hazard-stall cycles
- flush_count  out  COUNT_W  branch-flush events
- freeze_count  out  COUNT_W  freeze cycles

## Operation
- Hazard (combinational, sub-module):
  - match1 = src1_valid & (src1 == d); match2 = two_src & (src2 == d).
  - forward_en=0: hazard if (exe_wb_en & match(exe_dest)) | (mem_wb_en & match(mem_dest)).
  - forward_en=1: hazard only if exe_mem_read & exe_wb_en & match(exe_dest) (load-use).
- Priority, highest first: freeze > branch flush > hazard stall.
- freeze = mem_req & ~mem_ready while RUN, or ~mem_ready while MEM_WAIT. While freeze=1, hold_pc/hold_if_id/flush_* are forced 0, and stage registers hold via freeze.
- Branch (no freeze): flush_if_id=1, flush_id_exe=1, hold_*=0. Any hazard is ignored.
- Hazard (no freeze, no branch): hold_pc=1, hold_if_id=1, flush_id_exe=1.
- FSM states:
  - RUN: go to MEM_WAIT when mem_req & ~mem_ready.
  - MEM_WAIT: return to RUN on mem_ready. A wait counter increments each MEM_WAIT cycle. When it reaches TIMEOUT, mem_timeout sets and the FSM stays in MEM_WAIT.
  - Wait counter clears on entry to MEM_WAIT.
  - mem_timeout clears only on rst.
- Counters saturate at all-ones; no wrap.
  - stall_count +1 per hazard-stall cycle.
  - flush_count +1 per cycle with flush_if_id=1.
  - freeze_count +1 per cycle with freeze=1.
  - All counters update in the same cycle that qualifies them.

## Timing
- Control outputs are combinational from the current inputs plus state, and take effect at the next rising edge. Zero added latency.
- Load-use with forwarding: exactly one stall cycle. Without forwarding: stall persists until the producer leaves MEM (up to 2 cycles).
- Branch taken while freeze=1: suppressed. EXE is held, so branch_taken persists and the flush is applied in the first unfrozen cycle.
- mem_ready in the same cycle as mem_req: no freeze, FSM stays RUN.
- Reset, async at any time including mid-MEM_WAIT:
  - state=RUN, wait counter=0, all counters=0, mem_timeout=0.
  - While rst=1, all control outputs are 0.
- TIMEOUT boundary: mem_timeout rises on the edge ending the TIMEOUT-th consecutive MEM_WAIT cycle.

## Structure
- `REGFILE_ADDRESS_LEN comes from defines.v.
- New defines in defines.v: `PCTRL_RUN, `PCTRL_MEM_WAIT (1-bit state encodings).
- Sub-module hazard_detect: purely combinational compare logic producing `hazard`. It is instantiated once.
- The FSM, priority mux and counters live in pipeline_ctrl.

## Test plan
- src1=3, src1_valid=1, exe_dest=3, exe_wb_en=1, exe_mem_read=1, forward_en=1 for one cycle -> hold_pc=hold_if_id=flush_id_exe=1 that cycle; stall_count=1.
- Same as above with exe_mem_read=0, forward_en=0, then producer moves to MEM (mem_dest=3) -> 2 consecutive stall cycles; with forward_en=1 -> no stall.
- branch_taken=1 together with an active hazard -> flush_if_id=flush_id_exe=1, hold_*=0; flush_count=1, stall_count unchanged.
- mem_req=1, mem_ready low for 4 cycles then high -> freeze=1 for 4 cycles, state returns to RUN; freeze_count=4. Branch_taken asserted during the freeze flushes only in cycle 5.
- mem_req=1, mem_ready held 0 with TIMEOUT=8 -> mem_timeout=1 after 8 MEM_WAIT cycles and stays set. Asserting rst mid-wait -> all outputs and counters 0, state RUN.
- Force 2^COUNT_W+3 hazard cycles (COUNT_W=4) -> stall_count saturates at 15.
